// File: rtl/noc_link_rx_buffer.sv
// Credit-based NoC link receive buffer: FIFO of flits with first-word
// fall-through head and one registered credit pulse per popped entry.
module noc_link_rx_buffer #(
  parameter int BUFFER_DEPTH = 8,
  parameter int FLIT_WIDTH   = 128,
  parameter int USER_WIDTH   = 32,
  parameter int DEST_WIDTH   = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [FLIT_WIDTH-1:0]               data_in,
  input  logic [DEST_WIDTH-1:0]               dest_in,
  input  logic [USER_WIDTH-1:0]               user_in,
  input  logic                                is_tail_in,
  input  logic                                send_in,
  output logic                                credit_out,
  output logic [FLIT_WIDTH-1:0]               data_out,
  output logic [DEST_WIDTH-1:0]               dest_out,
  output logic [USER_WIDTH-1:0]               user_out,
  output logic                                is_tail_out,
  output logic                                valid_out,
  input  logic                                ready_in,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0]   count_out,
  output logic                                overflow_err
);

  localparam int PW = $clog2(BUFFER_DEPTH);
  localparam int CW = $clog2(BUFFER_DEPTH + 1);
  localparam int EW = FLIT_WIDTH + DEST_WIDTH + USER_WIDTH + 1;
  localparam logic [CW-1:0] FULL = CW'(BUFFER_DEPTH);

  logic [EW-1:0] mem_q [BUFFER_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          credit_q;
  logic          ovf_q, ovf_d;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  assign full  = (count_q == FULL);
  assign empty = (count_q == '0);
  // A flit arriving while full is dropped even if a pop frees a slot now.
  assign push  = send_in && !full;
  assign pop   = !empty && ready_in;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    if (send_in && full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      credit_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      credit_q <= pop;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {data_in, dest_in, user_in, is_tail_in};
  end

  assign head = mem_q[rd_ptr_q];
  assign {data_out, dest_out, user_out, is_tail_out} = head;

  assign valid_out    = !empty;
  assign count_out    = count_q;
  assign credit_out   = credit_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_noc_link_rx_buffer.sv
// Directed self-checking bench for noc_link_rx_buffer.
module tb_noc_link_rx_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] data_in;
  logic [7:0]   dest_in;
  logic [31:0]  user_in;
  logic         is_tail_in;
  logic         send_in;
  logic         credit_out;
  logic [127:0] data_out;
  logic [7:0]   dest_out;
  logic [31:0]  user_out;
  logic         is_tail_out;
  logic         valid_out;
  logic         ready_in;
  logic [3:0]   count_out;
  logic         overflow_err;

  int n_cmp = 0;
  int n_err = 0;

  noc_link_rx_buffer #(
    .BUFFER_DEPTH(8),
    .FLIT_WIDTH(128),
    .USER_WIDTH(32),
    .DEST_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .dest_in(dest_in),
    .user_in(user_in),
    .is_tail_in(is_tail_in),
    .send_in(send_in),
    .credit_out(credit_out),
    .data_out(data_out),
    .dest_out(dest_out),
    .user_out(user_out),
    .is_tail_out(is_tail_out),
    .valid_out(valid_out),
    .ready_in(ready_in),
    .count_out(count_out),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [127:0] d);
    send_in    = s;
    data_in    = d;
    dest_in    = d[7:0];
    user_in    = d[31:0];
    is_tail_in = d[0];
  endtask

  initial begin
    rst      = 1'b1;
    ready_in = 1'b0;
    drive(1'b0, '0);
    #1;
    check("rst_valid", 128'(valid_out), 0);
    check("rst_count", 128'(count_out), 0);
    check("rst_credit", 128'(credit_out), 0);
    check("rst_ovf", 128'(overflow_err), 0);
    #10;
    rst = 1'b0;

    // single flit, held for a few cycles then popped
    send_in    = 1'b1;
    data_in    = 128'hA5;
    dest_in    = 8'd3;
    user_in    = 32'd7;
    is_tail_in = 1'b1;
    step();
    drive(1'b0, '0);
    check("one_valid", 128'(valid_out), 1);
    check("one_count", 128'(count_out), 1);
    check("one_data", data_out, 128'hA5);
    check("one_dest", 128'(dest_out), 3);
    check("one_user", 128'(user_out), 7);
    check("one_tail", 128'(is_tail_out), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("one_hold_valid", 128'(valid_out), 1);
      check("one_hold_cr", 128'(credit_out), 0);
    end
    ready_in = 1'b1;
    step();
    check("one_pop_count", 128'(count_out), 0);
    check("one_pop_valid", 128'(valid_out), 0);
    check("one_pop_cr", 128'(credit_out), 1);
    ready_in = 1'b0;
    step();
    check("one_cr_gone", 128'(credit_out), 0);

    // fill to full, then overflow
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 128'(32'h100 + i));
      step();
      check("fill_cr", 128'(credit_out), 0);
    end
    check("fill_count", 128'(count_out), 8);
    check("fill_ovf", 128'(overflow_err), 0);
    drive(1'b1, 128'hDEAD);
    step();
    drive(1'b0, '0);
    check("ovf_set", 128'(overflow_err), 1);
    check("ovf_count", 128'(count_out), 8);
    ready_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_data", data_out, 128'(32'h100 + i));
      check("drain_tail", 128'(is_tail_out), 128'(i % 2));
      step();
      check("drain_cr", 128'(credit_out), 1);
    end
    check("drain_count", 128'(count_out), 0);
    check("drain_valid", 128'(valid_out), 0);
    check("ovf_sticky", 128'(overflow_err), 1);
    ready_in = 1'b0;
    step();
    check("drain_cr_end", 128'(credit_out), 0);

    // async reset with count=3 and a credit pending
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 128'(32'h500 + i));
      step();
    end
    drive(1'b0, '0);
    ready_in = 1'b1;
    step();
    check("pre_rst_count", 128'(count_out), 3);
    check("pre_rst_cr", 128'(credit_out), 1);
    ready_in = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("arst_valid", 128'(valid_out), 0);
    check("arst_count", 128'(count_out), 0);
    check("arst_cr", 128'(credit_out), 0);
    check("arst_ovf", 128'(overflow_err), 0);
    #2;
    rst = 1'b0;
    step();
    check("post_rst_cr", 128'(credit_out), 0);
    check("post_rst_valid", 128'(valid_out), 0);

    // streaming 20 flits with ready held high
    ready_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 128'(32'h200 + i));
      step();
      check("strm_count", 128'(count_out), 1);
      check("strm_data", data_out, 128'(32'h200 + i));
      check("strm_cr", 128'(credit_out), 128'(i > 0));
    end
    drive(1'b0, '0);
    step();
    check("strm_end_count", 128'(count_out), 0);
    check("strm_end_cr", 128'(credit_out), 1);
    ready_in = 1'b0;
    step();
    check("strm_idle_cr", 128'(credit_out), 0);

    // simultaneous push/pop at count=4
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 128'(32'h300 + i));
      step();
    end
    check("pp_count4", 128'(count_out), 4);
    drive(1'b1, 128'h304);
    ready_in = 1'b1;
    check("pp_head0", data_out, 128'h300);
    step();
    drive(1'b0, '0);
    check("pp_count", 128'(count_out), 4);
    check("pp_cr", 128'(credit_out), 1);
    for (int i = 1; i <= 4; i++) begin
      check("pp_order", data_out, 128'(32'h300 + i));
      step();
      check("pp_drain_cr", 128'(credit_out), 1);
    end
    check("pp_empty", 128'(count_out), 0);
    ready_in = 1'b0;

    // full with concurrent pop and send
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 128'(32'h400 + i));
      step();
    end
    check("fp_count8", 128'(count_out), 8);
    check("fp_ovf0", 128'(overflow_err), 0);
    drive(1'b1, 128'hBAD);
    ready_in = 1'b1;
    step();
    drive(1'b0, '0);
    check("fp_count", 128'(count_out), 7);
    check("fp_ovf", 128'(overflow_err), 1);
    check("fp_cr", 128'(credit_out), 1);
    for (int i = 1; i < 8; i++) begin
      check("fp_order", data_out, 128'(32'h400 + i));
      step();
    end
    check("fp_empty", 128'(count_out), 0);
    check("fp_valid", 128'(valid_out), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
